// File: rtl/uart_serial_phy.sv
// uart_serial_phy: 8N1 async serial PHY behind the USB CDC byte pipeline.
// The TX path serialises the in-stream onto tx. The RX path deserialises rx onto the out-stream.
// Bit timers are down-counters. A bit ends when its counter reaches zero.
// Defining UART_PARITY_EN adds an even parity bit after D7 and the parity_err output.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | TX: waiting for a byte (in_ready high); RX: waiting for falling edge
// S_START  | TX: driving start bit; RX: timing to start-bit centre (glitch check)
// S_DATA   | eight data bits, LSB first
// S_PARITY | even parity bit (UART_PARITY_EN only)
// S_STOP   | TX: driving stop bit; RX: timing to stop-bit centre, then deliver
module uart_serial_phy #(
  parameter int CLK_HZ      = 48000000,
  parameter int BAUD        = 115200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       framing_err,
`ifdef UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun_err
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- TX ----------------
  state_t          tx_state, tx_state_nxt;
  logic [CW-1:0]   tx_cnt, tx_cnt_nxt;
  logic [2:0]      tx_bit, tx_bit_nxt;
  logic [7:0]      tx_shift, tx_shift_nxt;
  logic            tx_nxt;
`ifdef UART_PARITY_EN
  logic            tx_par, tx_par_nxt;
`endif

  // TX state, bit timer and registered pin. Reset drives the pin high immediately.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx       <= tx_nxt;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_nxt;
`endif
    end
  end

  // TX next state. The pin value is decoded from the next state, so tx is a clean flop output.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    in_ready     = 1'b0;
    tx_nxt       = 1'b1;
`ifdef UART_PARITY_EN
    tx_par_nxt   = tx_par;
`endif
    case (tx_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tx_shift_nxt = in_data;
          tx_cnt_nxt   = BIT_LAST;
          tx_state_nxt = S_START;
`ifdef UART_PARITY_EN
          tx_par_nxt   = ^in_data;
`endif
        end
      end
      S_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt   = BIT_LAST;
          tx_bit_nxt   = '0;
          tx_state_nxt = S_DATA;
        end else tx_cnt_nxt = tx_cnt - CW'(1);
      end
      S_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt   = BIT_LAST;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          tx_bit_nxt   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_nxt = S_PARITY;
`else
            tx_state_nxt = S_STOP;
`endif
          end
        end else tx_cnt_nxt = tx_cnt - CW'(1);
      end
      S_PARITY: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt   = BIT_LAST;
          tx_state_nxt = S_STOP;
        end else tx_cnt_nxt = tx_cnt - CW'(1);
      end
      S_STOP: begin
        if (tx_cnt == '0) tx_state_nxt = S_IDLE;
        else tx_cnt_nxt = tx_cnt - CW'(1);
      end
      default: tx_state_nxt = S_IDLE;
    endcase
    case (tx_state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = tx_shift_nxt[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_nxt = tx_par_nxt;
`endif
      default:  tx_nxt = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s, rx_prev, rx_armed, rx_armed_nxt;
  state_t                 rx_state, rx_state_nxt;
  logic [CW-1:0]          rx_cnt, rx_cnt_nxt;
  logic [2:0]             rx_bit, rx_bit_nxt;
  logic [7:0]             rx_shift, rx_shift_nxt;
  logic                   rx_deliver, rx_ferr;
`ifdef UART_PARITY_EN
  logic                   rx_par_bad, rx_par_bad_nxt, rx_perr;
`endif

  assign rx_s = rx_sync[SYNC_STAGES-1];

  // Synchroniser, edge history and RX state. The chain resets to the idle-high line level.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync  <= '1;
      rx_prev  <= 1'b1;
      rx_armed <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      rx_sync  <= {rx_sync[SYNC_STAGES-2:0], rx};
      rx_prev  <= rx_s;
      rx_armed <= rx_armed_nxt;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
`ifdef UART_PARITY_EN
      rx_par_bad <= rx_par_bad_nxt;
`endif
    end
  end

  // RX next state. After a bad stop bit, edge detection stays disarmed until the line is seen high.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_armed_nxt = rx_armed;
    rx_deliver   = 1'b0;
    rx_ferr      = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_nxt = rx_par_bad;
    rx_perr        = 1'b0;
`endif
    case (rx_state)
      S_IDLE: begin
        if (!rx_armed) begin
          if (rx_s) rx_armed_nxt = 1'b1;
        end else if (rx_prev && !rx_s) begin
          rx_cnt_nxt   = HALF_LAST;
          rx_state_nxt = S_START;
        end
      end
      S_START: begin
        if (rx_cnt == '0) begin
          if (rx_s) rx_state_nxt = S_IDLE;
          else begin
            rx_cnt_nxt   = BIT_LAST;
            rx_bit_nxt   = '0;
            rx_state_nxt = S_DATA;
          end
        end else rx_cnt_nxt = rx_cnt - CW'(1);
      end
      S_DATA: begin
        if (rx_cnt == '0) begin
          rx_cnt_nxt   = BIT_LAST;
          rx_shift_nxt = {rx_s, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_nxt = S_PARITY;
`else
            rx_state_nxt = S_STOP;
`endif
          end
        end else rx_cnt_nxt = rx_cnt - CW'(1);
      end
      S_PARITY: begin
        if (rx_cnt == '0) begin
          rx_cnt_nxt   = BIT_LAST;
          rx_state_nxt = S_STOP;
`ifdef UART_PARITY_EN
          rx_par_bad_nxt = rx_s ^ (^rx_shift);
`endif
        end else rx_cnt_nxt = rx_cnt - CW'(1);
      end
      S_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_nxt = S_IDLE;
          if (!rx_s) begin
            rx_ferr      = 1'b1;
            rx_armed_nxt = 1'b0;
          end
`ifdef UART_PARITY_EN
          else if (rx_par_bad) rx_perr = 1'b1;
`endif
          else rx_deliver = 1'b1;
        end else rx_cnt_nxt = rx_cnt - CW'(1);
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  // Holding register and one-cycle error pulses. A byte arriving while the register is full and not drained is dropped.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      framing_err <= rx_ferr;
      overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err  <= rx_perr;
`endif
      if (rx_deliver) begin
        if (!out_valid || out_ready) begin
          out_data  <= rx_shift;
          out_valid <= 1'b1;
        end else overrun_err <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule
